// File: rtl/rr_shared_adder_arb.sv
// Round-robin arbiter sharing one registered DW-bit adder between N_REQ
// operand channels, with a single valid/ready result stream.
module rr_shared_adder_arb #(
    parameter int DW    = 32,
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [DW-1:0]       s_data,
    output logic [IDW-1:0]      s_id,
    output logic                s_ovf,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [CNT_W-1:0]    res_cnt
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]    data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    int               idx;
    logic             take;
    logic             xfer;
    logic [DW-1:0]    a_sel, b_sel;
    logic [DW:0]      sum;

    assign take = !valid_q || s_ready;

    // Search ptr, ptr+1, ... wrapping, first valid requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign xfer = found && take && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[win] = 1'b1;
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[i*DW +: DW];
                b_sel = req_b[i*DW +: DW];
            end
        end
    end

    assign sum = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = sum[DW-1:0];
            ovf_d   = sum[DW];
            id_d    = win;
            ptr_d   = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end else if (s_ready) begin
            valid_d = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(valid_q && s_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_valid = valid_q;
    assign s_data  = data_q;
    assign s_id    = id_q;
    assign s_ovf   = ovf_q;
    assign res_cnt = cnt_q;

endmodule

// File: tb/tb_rr_shared_adder_arb.sv
// Directed checks for rr_shared_adder_arb: reset, grant order, backpressure,
// carry-out and result-counter wrap.
module tb_rr_shared_adder_arb;

    localparam int DW    = 32;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam int CNT_W = 4;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [DW-1:0]       s_data;
    logic [IDW-1:0]      s_id;
    logic                s_ovf;
    logic                s_valid;
    logic                s_ready;
    logic [CNT_W-1:0]    res_cnt;

    int checks;
    int failures;

    rr_shared_adder_arb #(
        .DW(DW), .N_REQ(N_REQ), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .s_data(s_data), .s_id(s_id), .s_ovf(s_ovf),
        .s_valid(s_valid), .s_ready(s_ready),
        .res_cnt(res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        s_ready   = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'b1111;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = {$urandom, $urandom, $urandom, $urandom};
        set_op(0, 32'h1234_0000, 32'h0000_5678);
        s_ready = 1'b0;
        step();
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL pre_reset_load got v=%b d=%h exp v=1 d=12345678",
                     s_valid, s_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({s_valid, s_data, s_id, s_ovf, res_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset_out got v=%b d=%h id=%0d o=%b c=%0d exp all 0",
                     s_valid, s_data, s_id, s_ovf, res_cnt);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got %b exp 0000", req_ready);
        end
        #1;
        req_valid = 4'b1010;
        s_ready   = 1'b1;
        rst       = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL post_reset_grant got %b exp 0010", req_ready);
        end
        step();
        checks++;
        if (s_valid !== 1'b1 || s_id !== 2'd1) begin
            failures++;
            $display("FAIL post_reset_id got v=%b id=%0d exp v=1 id=1",
                     s_valid, s_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_op(2, 32'd5, 32'd7);
        req_valid = 4'b0100;
        s_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready got %b exp 0100", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (s_valid !== 1'b1 || s_data !== 32'd12 || s_id !== 2'd2 ||
            s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_result got v=%b d=%0d id=%0d o=%b exp 1 12 2 0",
                     s_valid, s_data, s_id, s_ovf);
        end
        step();
        checks++;
        if (s_valid !== 1'b0 || res_cnt !== 4'd1) begin
            failures++;
            $display("FAIL single_drain got v=%b cnt=%0d exp v=0 cnt=1",
                     s_valid, res_cnt);
        end
    endtask

    task automatic test_fairness();
        logic [IDW-1:0] exp_id;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, i, 32'd10);
        req_valid = 4'b1111;
        s_ready   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_id = IDW'(c % 4);
            checks++;
            if (s_valid !== 1'b1 || s_id !== exp_id ||
                s_data !== 32'(10 + c % 4)) begin
                failures++;
                $display("FAIL fair_c%0d got v=%b id=%0d d=%0d exp v=1 id=%0d d=%0d",
                         c, s_valid, s_id, s_data, exp_id, 10 + c % 4);
            end
        end
        req_valid = '0;
        step();
        checks++;
        if (res_cnt !== 4'd8) begin
            failures++;
            $display("FAIL fair_count got %0d exp 8", res_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, i, 32'd10);
        req_valid = 4'b1111;
        s_ready   = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (s_valid !== 1'b1 || s_id !== 2'd0 || s_data !== 32'd10 ||
                req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold_c%0d got v=%b id=%0d d=%0d rdy=%b exp 1 0 10 0000",
                         c, s_valid, s_id, s_data, req_ready);
            end
            step();
        end
        s_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ready got %b exp 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (s_valid !== 1'b1 || s_id !== 2'd1 || s_data !== 32'd11 ||
            res_cnt !== 4'd1) begin
            failures++;
            $display("FAIL bp_next got v=%b id=%0d d=%0d cnt=%0d exp 1 1 11 1",
                     s_valid, s_id, s_data, res_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        s_ready = 1'b1;
        set_op(0, 32'hFFFF_FFFF, 32'h2);
        req_valid = 4'b0001;
        step();
        checks++;
        if (s_data !== 32'h1 || s_ovf !== 1'b1 || s_id !== 2'd0) begin
            failures++;
            $display("FAIL ovf_carry got d=%h o=%b id=%0d exp 00000001 1 0",
                     s_data, s_ovf, s_id);
        end
        set_op(0, 32'h7FFF_FFFF, 32'h1);
        step();
        req_valid = '0;
        checks++;
        if (s_data !== 32'h8000_0000 || s_ovf !== 1'b0 || s_id !== 2'd0) begin
            failures++;
            $display("FAIL ovf_nocarry got d=%h o=%b id=%0d exp 80000000 0 0",
                     s_data, s_ovf, s_id);
        end
    endtask

    task automatic test_skip();
        logic [IDW-1:0] exp_ids [3];
        exp_ids = '{2'd3, 2'd1, 2'd3};
        do_reset();
        s_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_op(i, i, 32'd100);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (s_id !== exp_ids[c] || s_data !== 32'(100 + exp_ids[c])) begin
                failures++;
                $display("FAIL skip_c%0d got id=%0d d=%0d exp id=%0d",
                         c, s_id, s_data, exp_ids[c]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        s_ready = 1'b1;
        set_op(0, 32'd1, 32'd1);
        req_valid = 4'b0001;
        for (int c = 0; c < 17; c++) step();
        checks++;
        if (res_cnt !== 4'd0) begin
            failures++;
            $display("FAIL cnt_wrap16 got %0d exp 0", res_cnt);
        end
        req_valid = '0;
        step();
        checks++;
        if (res_cnt !== 4'd1 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL cnt_wrap17 got cnt=%0d v=%b exp cnt=1 v=0",
                     res_cnt, s_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        s_ready   = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_skip();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
